// File: rtl/sos_pattern_module.sv
// Plays one Morse "S O S" (27 time units) on LED_Out for each accepted SOS_En
// pulse; Busy covers the pattern and Done pulses for one cycle at its end.
module sos_pattern_module #(
   parameter int unsigned T_UNIT = 25_000_000
) (
   input  logic CLK,
   input  logic RST_n,
   input  logic SOS_En,
   output logic LED_Out,
   output logic Busy,
   output logic Done
);

   typedef enum logic [1:0] {IDLE, MARK, SPACE} state_t;

   localparam logic [24:0] CYC_LAST  = 25'(T_UNIT - 1);
   localparam logic [3:0]  LAST_ELEM = 4'd8;

   state_t      state, state_d;
   logic [24:0] cyc_cnt, cyc_cnt_d;
   logic [1:0]  unit_cnt, unit_cnt_d;
   logic [3:0]  elem_idx, elem_idx_d;
   logic        led_d, busy_d, done_d;

   logic        unit_end, is_dash, long_gap, units_done;
   logic [1:0]  unit_last;

   // Elements 3..5 are the dashes of "O"; gaps after 2 and 5 separate letters
   assign is_dash  = (elem_idx == 4'd3) || (elem_idx == 4'd4) || (elem_idx == 4'd5);
   assign long_gap = (elem_idx == 4'd2) || (elem_idx == 4'd5);
   assign unit_end = (cyc_cnt == CYC_LAST);

   always_comb begin
      unit_last = 2'd0;
      if ((state == MARK && is_dash) || (state == SPACE && long_gap))
         unit_last = 2'd2;
   end

   assign units_done = unit_end && (unit_cnt == unit_last);

   always_comb begin
      state_d    = state;
      cyc_cnt_d  = cyc_cnt;
      unit_cnt_d = unit_cnt;
      elem_idx_d = elem_idx;
      done_d     = 1'b0;
      case (state)
         IDLE: begin
            cyc_cnt_d  = '0;
            unit_cnt_d = '0;
            elem_idx_d = '0;
            if (SOS_En)
               state_d = MARK;
         end
         MARK, SPACE: begin
            if (units_done) begin
               cyc_cnt_d  = '0;
               unit_cnt_d = '0;
               if (state == SPACE) begin
                  state_d    = MARK;
                  elem_idx_d = elem_idx + 4'd1;
               end else if (elem_idx < LAST_ELEM) begin
                  state_d = SPACE;
               end else begin
                  state_d    = IDLE;
                  elem_idx_d = '0;
                  done_d     = 1'b1;
               end
            end else if (unit_end) begin
               cyc_cnt_d  = '0;
               unit_cnt_d = unit_cnt + 2'd1;
            end else begin
               cyc_cnt_d = cyc_cnt + 25'd1;
            end
         end
         default: begin
            state_d    = IDLE;
            cyc_cnt_d  = '0;
            unit_cnt_d = '0;
            elem_idx_d = '0;
         end
      endcase
      led_d  = (state_d == MARK);
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state    <= IDLE;
         cyc_cnt  <= '0;
         unit_cnt <= '0;
         elem_idx <= '0;
         LED_Out  <= 1'b0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
      end else begin
         state    <= state_d;
         cyc_cnt  <= cyc_cnt_d;
         unit_cnt <= unit_cnt_d;
         elem_idx <= elem_idx_d;
         LED_Out  <= led_d;
         Busy     <= busy_d;
         Done     <= done_d;
      end
   end

endmodule

// File: tb/tb_sos_pattern_module.sv
// Scoreboard bench for sos_pattern_module at T_UNIT=4 (108-cycle pattern).
module tb_sos_pattern_module;

   logic CLK = 1'b0;
   logic RST_n = 1'b0;
   logic SOS_En = 1'b0;
   logic LED_Out, Busy, Done;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;
   logic [2:0] exp_q[$];

   sos_pattern_module #(.T_UNIT(4)) dut (
      .CLK(CLK), .RST_n(RST_n), .SOS_En(SOS_En),
      .LED_Out(LED_Out), .Busy(Busy), .Done(Done)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;

   // Expected {LED,Busy,Done} p cycles after the accepting edge
   function automatic logic [2:0] exp_at(int p);
      int lo[9] = '{0, 8, 16, 32, 48, 64, 88, 96, 104};
      int hi[9] = '{3, 11, 19, 43, 59, 75, 91, 99, 107};
      logic led = 1'b0;
      for (int i = 0; i < 9; i++)
         if (p >= lo[i] && p <= hi[i]) led = 1'b1;
      return {led, (p >= 0 && p < 108), (p == 108)};
   endfunction

   // Drive SOS_En for the next edge and queue the output expected after it
   task automatic step(input logic en, input logic [2:0] e);
      @(negedge CLK);
      SOS_En = en;
      exp_q.push_back(e);
   endtask

   task automatic check(input string name, input logic [2:0] got, input logic [2:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: {led,busy,done} got %b want %b", name, got, want);
      end
   endtask

   // Monitor: outputs are presented every cycle; compare against the queue head
   initial begin
      logic [2:0] e;
      forever begin
         @(posedge CLK);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_checks++;
            if ({LED_Out, Busy, Done} !== e) begin
               n_fail++;
               $display("FAIL scoreboard cyc %0d: {led,busy,done} got %b want %b",
                        cyc, {LED_Out, Busy, Done}, e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state, with the clock running
      repeat (3) @(posedge CLK);
      #2;
      check("reset_state", {LED_Out, Busy, Done}, 3'b000);

      // Start requested on the first edge after release; single pattern
      @(negedge CLK);
      RST_n = 1'b1;
      SOS_En = 1'b1;
      exp_q.push_back(exp_at(0));
      for (int p = 1; p <= 120; p++) step(1'b0, exp_at(p));

      // Extra requests while busy and on the Done edge are ignored
      step(1'b1, exp_at(0));
      for (int p = 1; p <= 115; p++)
         step((p == 5 || p == 40 || p == 107 || p == 108), exp_at(p));

      // Held high: back-to-back patterns, period 109, then drop
      step(1'b1, exp_at(0));
      for (int p = 1; p <= 230; p++)
         step(p < 218, (p < 218) ? exp_at(p % 109) : exp_at(p - 109));

      // Reset mid-dash at cycle 50 aborts without Done
      step(1'b1, exp_at(0));
      for (int p = 1; p <= 50; p++) step(1'b0, exp_at(p));
      @(posedge CLK);
      #2;
      check("pre_reset_dash", {LED_Out, Busy, Done}, 3'b110);
      RST_n = 1'b0;
      #1;
      check("async_reset", {LED_Out, Busy, Done}, 3'b000);
      @(negedge CLK);
      #1;
      check("held_reset", {LED_Out, Busy, Done}, 3'b000);
      RST_n = 1'b1;

      // Quiet for 500 cycles: nothing moves, no stray Done
      for (int p = 0; p < 500; p++) step(1'b0, 3'b000);

      // Fresh request restarts from element 0 with normal timing
      step(1'b1, exp_at(0));
      for (int p = 1; p <= 112; p++) step(1'b0, exp_at(p));

      @(posedge CLK);
      #2;
      check("queue_drained", {2'b00, exp_q.size() == 0}, 3'b001);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/sos_pattern_module.md
SOS_PATTERN_MODULE -- requirements
Module: sos_pattern_module

Interface
REQ-001 Parameter T_UNIT, default 25_000_000, Morse time unit in CLK cycles (0.5 s at 50 MHz); legal range 2..2^25-1.
REQ-002 CLK  input  1  system clock, all logic on rising edge.
REQ-003 RST_n  input  1  reset, asynchronous, active-low.
REQ-004 SOS_En  input  1  start request; single-cycle pulse from the 20 s period controller; level-sampled.
REQ-005 LED_Out  output  1  Morse-keyed LED drive, 1 = lit; registered.
REQ-006 Busy  output  1  high while a pattern is playing; registered.
REQ-007 Done  output  1  one-cycle pulse at pattern completion; registered.

Function
REQ-008 The pattern SHALL be "S O S" in Morse: dot, dot, dot, dash, dash, dash, dot, dot, dot (9 elements).
REQ-009 Timing SHALL be: dot on = 1 unit, dash on = 3 units, intra-letter gap = 1 unit, inter-letter gap = 3 units, no trailing gap; total 27 units = 27*T_UNIT cycles.
REQ-010 The FSM SHALL have states IDLE, MARK (LED lit), SPACE (LED dark between elements).
REQ-011 IDLE: LED_Out=0, Busy=0; SOS_En=1 at a rising edge SHALL move to MARK with element index 0, LED_Out=1, Busy=1 after that same edge.
REQ-012 MARK: after the element's on-time (1 or 3 units) SHALL go to SPACE if the element index < 8, else to IDLE.
REQ-013 SPACE: after 3 units if the finished element is index 2 or 5, else after 1 unit, SHALL go to MARK with the element index incremented.
REQ-014 Timing SHALL use a cycle counter (0..T_UNIT-1, 25 bits), a unit counter (0..2), and an element index (0..8, 4 bits); all clear on every state change.
REQ-015 Cycle-exact: with SOS_En sampled at edge k, LED_Out SHALL be high during units [0,1),[2,3),[4,5),[8,11),[12,15),[16,19),[22,23),[24,25),[26,27) relative to edge k.
REQ-016 At edge k+27*T_UNIT: LED_Out=0, Busy=0, Done=1; Done SHALL drop at the next edge.
REQ-017 SOS_En while Busy=1 SHALL be ignored (no restart, no queuing).
REQ-018 SOS_En=1 on the edge where Busy falls (Done edge) is not accepted; SOS_En=1 during the cycle Done=1 (Busy=0) SHALL start a new pattern at the following edge.
REQ-019 Done SHALL never assert other than at completion of a full 27-unit pattern.
REQ-020 The counters SHALL not wrap: the cycle counter returns to 0 only at a unit boundary.

Reset
REQ-021 RST_n=0 SHALL immediately force IDLE, LED_Out=0, Busy=0, Done=0, all counters to 0, regardless of clock.
REQ-022 Reset mid-pattern SHALL abort with no Done pulse; after release, only a fresh SOS_En starts a pattern from element 0.
REQ-023 SOS_En=1 at the first edge after RST_n release SHALL be accepted normally.

Verification (T_UNIT=4, total 108 cycles)
REQ-024 Single SOS_En pulse at edge 0 -> LED_Out high cycles 0-3, 8-11, 16-19, 32-43, 48-59, 64-75, 88-91, 96-99, 104-107; Busy high 0-107; Done high only in cycle 108.
REQ-025 Extra SOS_En pulses at cycles 5, 40, 107 -> waveform identical to REQ-024; no restart.
REQ-026 SOS_En held high continuously -> patterns back-to-back, one cycle gap (the Done cycle), period 109 cycles, Done once per period.
REQ-027 RST_n pulsed low at cycle 50 (mid-dash) -> LED_Out, Busy drop asynchronously; no Done; next SOS_En restarts at element 0 with the REQ-024 timing.
REQ-028 No SOS_En for 500 cycles after reset -> LED_Out=0, Busy=0, Done=0 throughout.
